// File: rtl/trig_pkg.sv
// Shared definitions for the triggered frame scheduler: frame geometry,
// the scheduler state enum and the byte/CRC helper functions.
package trig_pkg;

    // Frame geometry: slots 0..7 data, slot 8 CRC, slot 9 gap
    localparam logic [3:0] FRAME_LEN      = 4'd10;
    localparam logic [3:0] CRC_SLOT       = 4'd8;
    localparam logic [3:0] GAP_SLOT       = FRAME_LEN - 4'd1;
    localparam logic [3:0] LAST_DATA_SLOT = CRC_SLOT - 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2,
        ST_GAP  = 2'd3
    } trig_state_e;

    // Byte n of a 64-bit payload, most significant byte first
    function automatic logic [7:0] frame_byte(input logic [63:0] p, input logic [3:0] n);
        logic [63:0] sh;
        sh = p << {n[2:0], 3'b000};
        return sh[63:56];
    endfunction

    // One byte step of an MSB-first, non-reflected CRC-8
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                             input logic [7:0] data,
                                             input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ poly;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping modulo NUM_REQ) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         idx
);

    logic found_s;

    // Scan requesters in priority order starting at the pointer
    always_comb begin
        gnt     = '0;
        idx     = 3'd0;
        found_s = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found_s && req[k] && (k == ((int'(ptr) + off) % NUM_REQ))) begin
                    found_s = 1'b1;
                    gnt[k]  = 1'b1;
                    idx     = 3'(k);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/trig_frame_scheduler.sv
// Triggered frame scheduler: arbitrates NUM_REQ requesters round-robin and
// serialises a 10-slot frame (8 payload bytes, CRC-8, gap) per grant.
// Optional feature: define TRIG_SCHED_SRC_ID_EN to emit a source-ID byte
// {5'b10100, owner} in the gap slot (not covered by the CRC).
module trig_frame_scheduler
    import trig_pkg::*;
#(
    parameter int         NUM_REQ    = 4,
    parameter logic [7:0] POLYNOMIAL = 8'h07,
    parameter logic [7:0] INITIAL    = 8'hFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ*64-1:0]   payload_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [7:0]              tx_data_o,
    output logic                    tx_valid_o,
    output logic                    tx_sof_o,
    output logic                    tx_eof_o,
    output logic [3:0]              slot_o,
    output logic [2:0]              owner_o,
    output logic                    busy_o
);

    trig_state_e          state_r, state_nx_s;
    logic [3:0]           slot_r, slot_nx_s;
    logic [2:0]           owner_r, owner_nx_s;
    logic [2:0]           ptr_r, ptr_nx_s;
    logic [63:0]          payload_r, payload_nx_s;
    logic [7:0]           crc_r, crc_nx_s;

    logic [NUM_REQ-1:0]   win_gnt_s;
    logic [2:0]           win_idx_s;
    logic [63:0]          win_payload_s;
    logic [7:0]           cur_byte_s;

    logic [NUM_REQ-1:0]   gnt_nx_s, gnt_r;
    logic [7:0]           data_nx_s, tx_data_r;
    logic                 valid_nx_s, tx_valid_r;
    logic                 sof_nx_s, tx_sof_r;
    logic                 eof_nx_s, tx_eof_r;
    logic                 busy_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req (req_i),
        .ptr (ptr_r),
        .gnt (win_gnt_s),
        .idx (win_idx_s)
    );

    // Select the winning requester's payload lane (AND-OR mux on the one-hot grant)
    always_comb begin
        win_payload_s = 64'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            win_payload_s = win_payload_s | (payload_i[k*64 +: 64] & {64{win_gnt_s[k]}});
        end
    end

    // Frame sequencing: next state, latched frame data and next output values
    always_comb begin
        state_nx_s   = state_r;
        slot_nx_s    = slot_r;
        owner_nx_s   = owner_r;
        ptr_nx_s     = ptr_r;
        payload_nx_s = payload_r;
        crc_nx_s     = crc_r;
        cur_byte_s   = 8'h00;
        gnt_nx_s     = '0;
        data_nx_s    = 8'h00;
        valid_nx_s   = 1'b0;
        sof_nx_s     = 1'b0;
        eof_nx_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_GAP: begin
                if (|req_i) begin
                    state_nx_s   = ST_DATA;
                    slot_nx_s    = 4'd0;
                    owner_nx_s   = win_idx_s;
                    payload_nx_s = win_payload_s;
                    crc_nx_s     = INITIAL;
                    if (win_idx_s == 3'(NUM_REQ - 1)) begin
                        ptr_nx_s = 3'd0;
                    end else begin
                        ptr_nx_s = win_idx_s + 3'd1;
                    end
                    gnt_nx_s     = win_gnt_s;
                    data_nx_s    = frame_byte(win_payload_s, 4'd0);
                    valid_nx_s   = 1'b1;
                    sof_nx_s     = 1'b1;
                end else begin
                    state_nx_s   = ST_IDLE;
                    slot_nx_s    = 4'd0;
                end
            end
            ST_DATA: begin
                cur_byte_s = frame_byte(payload_r, slot_r);
                crc_nx_s   = crc8_byte(crc_r, cur_byte_s, POLYNOMIAL);
                valid_nx_s = 1'b1;
                if (slot_r == LAST_DATA_SLOT) begin
                    state_nx_s = ST_CRC;
                    slot_nx_s  = CRC_SLOT;
                    data_nx_s  = crc_nx_s;
                    eof_nx_s   = 1'b1;
                end else begin
                    slot_nx_s  = slot_r + 4'd1;
                    data_nx_s  = frame_byte(payload_r, slot_r + 4'd1);
                end
            end
            ST_CRC: begin
                state_nx_s = ST_GAP;
                slot_nx_s  = GAP_SLOT;
`ifdef TRIG_SCHED_SRC_ID_EN
                data_nx_s  = {5'b10100, owner_r};
                valid_nx_s = 1'b1;
`endif
            end
            default: begin
                state_nx_s = ST_IDLE;
                slot_nx_s  = 4'd0;
            end
        endcase
    end

    // Scheduler state, pointer and latched frame contents
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            slot_r    <= 4'd0;
            owner_r   <= 3'd0;
            ptr_r     <= 3'd0;
            payload_r <= 64'd0;
            crc_r     <= 8'h00;
        end else begin
            state_r   <= state_nx_s;
            slot_r    <= slot_nx_s;
            owner_r   <= owner_nx_s;
            ptr_r     <= ptr_nx_s;
            payload_r <= payload_nx_s;
            crc_r     <= crc_nx_s;
        end
    end

    // Registered transmit-side outputs, aligned with the slot they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_r      <= '0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            tx_sof_r   <= 1'b0;
            tx_eof_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            gnt_r      <= gnt_nx_s;
            tx_data_r  <= data_nx_s;
            tx_valid_r <= valid_nx_s;
            tx_sof_r   <= sof_nx_s;
            tx_eof_r   <= eof_nx_s;
            busy_r     <= (state_nx_s != ST_IDLE);
        end
    end

    assign gnt_o      = gnt_r;
    assign tx_data_o  = tx_data_r;
    assign tx_valid_o = tx_valid_r;
    assign tx_sof_o   = tx_sof_r;
    assign tx_eof_o   = tx_eof_r;
    assign slot_o     = slot_r;
    assign owner_o    = owner_r;
    assign busy_o     = busy_r;

endmodule

// File: tb/tb_trig_frame_scheduler.sv
// Scoreboard bench for trig_frame_scheduler: a frame-level reference model
// pushes the expected per-cycle output record; a monitor pops and compares.
module tb_trig_frame_scheduler;

    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req_i;
    logic [N*64-1:0] payload_i;
    logic [N-1:0]   gnt_o;
    logic [7:0]     tx_data_o;
    logic           tx_valid_o;
    logic           tx_sof_o;
    logic           tx_eof_o;
    logic [3:0]     slot_o;
    logic [2:0]     owner_o;
    logic           busy_o;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [7:0]   data;
        logic         valid;
        logic         sof;
        logic         eof;
        logic [3:0]   slot;
        logic [2:0]   owner;
        logic         busy;
    } rec_t;

    rec_t frame_q[$];
    rec_t exp_q[$];

    int   total = 0;
    int   bad   = 0;
    int   ptr_m = 0;
    int   owner_m = 0;
    logic [N-1:0] pend = '0;
    logic         fix_en = 1'b0;
    logic [63:0]  fix_val = 64'd0;

    trig_frame_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_i),
        .payload_i  (payload_i),
        .gnt_o      (gnt_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_sof_o   (tx_sof_o),
        .tx_eof_o   (tx_eof_o),
        .slot_o     (slot_o),
        .owner_o    (owner_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial CRC-8 over the 64-bit message (poly 0x07, seed 0xFF)
    function automatic logic [7:0] ref_crc(input logic [63:0] m);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        for (int i = 63; i >= 0; i--) begin
            fb = c[7] ^ m[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    function automatic rec_t idle_rec(input int own);
        rec_t r;
        r = '0;
        r.owner = 3'(own);
        return r;
    endfunction

    // One bench cycle: drive inputs at negedge and predict the next output cycle
    task automatic step(input logic rst_v, input logic [N-1:0] glitch);
        rec_t r;
        int   w;
        logic [63:0] msg;
        logic [7:0]  crc;
        @(negedge clk);
        reset = rst_v;
        req_i = pend | glitch;
        for (int k = 0; k < N*2; k++) payload_i[k*32 +: 32] = $urandom;
        if (fix_en) payload_i[63:0] = fix_val;
        if (!rst_v) begin
            frame_q.delete();
            ptr_m   = 0;
            owner_m = 0;
            exp_q.push_back(idle_rec(0));
            #1;
            total++;
            if (tx_valid_o !== 1'b0 || gnt_o !== '0 || busy_o !== 1'b0 || slot_o !== 4'd0 ||
                tx_data_o !== 8'h00 || owner_o !== 3'd0) begin
                bad++;
                $display("FAIL reset_outputs t=%0t got v=%b gnt=%b busy=%b slot=%0d data=%h own=%0d want all zero",
                         $time, tx_valid_o, gnt_o, busy_o, slot_o, tx_data_o, owner_o);
            end
        end else begin
            if (frame_q.size() == 0 && req_i != '0) begin
                w = -1;
                for (int o = 0; o < N; o++) begin
                    int c;
                    c = (ptr_m + o) % N;
                    if (w < 0 && req_i[c]) w = c;
                end
                msg = payload_i[w*64 +: 64];
                crc = ref_crc(msg);
                for (int s = 0; s < 10; s++) begin
                    r       = '0;
                    r.gnt   = (s == 0) ? N'(1 << w) : '0;
                    r.valid = (s < 9);
                    if (s < 8) r.data = msg[63 - 8*s -: 8];
                    else if (s == 8) r.data = crc;
                    else r.data = 8'h00;
`ifdef TRIG_SCHED_SRC_ID_EN
                    if (s == 9) begin
                        r.data  = {5'b10100, 3'(w)};
                        r.valid = 1'b1;
                    end
`endif
                    r.sof   = (s == 0);
                    r.eof   = (s == 8);
                    r.slot  = 4'(s);
                    r.owner = 3'(w);
                    r.busy  = 1'b1;
                    frame_q.push_back(r);
                end
                pend[w] = 1'b0;
                ptr_m   = (w + 1) % N;
                owner_m = w;
            end
            if (frame_q.size() > 0) exp_q.push_back(frame_q.pop_front());
            else exp_q.push_back(idle_rec(owner_m));
        end
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 30; i++) begin
            if (pend == '0) break;
            step(1'b1, '0);
        end
    endtask

    // Monitor: compare each output cycle against the oldest expected record
    initial begin
        rec_t e, a;
        forever begin
            @(posedge clk);
            #1;
            a = {gnt_o, tx_data_o, tx_valid_o, tx_sof_o, tx_eof_o, slot_o, owner_o, busy_o};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow t=%0t got %h want a queued record", $time, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL cycle t=%0t got gnt=%b data=%h v=%b sof=%b eof=%b slot=%0d own=%0d busy=%b want gnt=%b data=%h v=%b sof=%b eof=%b slot=%0d own=%0d busy=%b",
                             $time, a.gnt, a.data, a.valid, a.sof, a.eof, a.slot, a.owner, a.busy,
                             e.gnt, e.data, e.valid, e.sof, e.eof, e.slot, e.owner, e.busy);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        logic [N-1:0] gl;
        logic         rv;
        reset     = 1'b0;
        req_i     = '0;
        payload_i = '0;
        exp_q.push_back(idle_rec(0));
        step(1'b0, '0);
        step(1'b0, '0);
        repeat (3) step(1'b1, '0);

        // Single request with known payload
        fix_en  = 1'b1;
        fix_val = 64'h0102030405060708;
        pend    = 4'b0001;
        wait_grant();
        repeat (15) step(1'b1, '0);
        fix_en  = 1'b0;

        // Full contention from a fresh pointer
        step(1'b0, '0);
        repeat (55) step(1'b1, 4'b1111);
        repeat (12) step(1'b1, '0);

        // Pointer after granting requester 2
        step(1'b0, '0);
        pend = 4'b0100;
        wait_grant();
        pend = 4'b0101;
        repeat (25) step(1'b1, '0);

        // Reset mid-frame, then a fresh frame
        pend = 4'b0010;
        wait_grant();
        repeat (4) step(1'b1, '0);
        step(1'b0, '0);
        pend = 4'b1000;
        repeat (15) step(1'b1, '0);

        // Withdrawn request pulsed during another frame's data
        pend = 4'b0001;
        wait_grant();
        step(1'b1, 4'b0010);
        repeat (15) step(1'b1, '0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) pend = pend | N'($urandom);
            gl = ($urandom_range(0, 9) == 0) ? N'(1 << $urandom_range(0, N-1)) : '0;
            rv = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            step(rv, gl);
        end

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
